bus_sync_mcp: RTL

//   Multi-cycle-path (MCP) bus synchronizer for the AHB2AHB bridge CDC path. Lives in the destination domain.

---
 rtl/bus_sync_mcp_pkg.sv | 19 +
 rtl/bus_sync_mcp_sync_chain.sv | 41 ++++
 rtl/bus_sync_mcp.sv | 114 +++++++++++
 3 files changed

// File: rtl/bus_sync_mcp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sync_mcp_pkg
//  Description : Constants shared by the CDC blocks. EN_MODE selects how a
//                synchronized qualifier is turned into a transfer event.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_sync_mcp_pkg;

  // Qualifier interpretation for multi-cycle-path synchronizers.
  localparam int EN_MODE_LEVEL  = 0;  // event on synchronized rising edge
  localparam int EN_MODE_TOGGLE = 1;  // event on any synchronized edge

  // Smallest chain that still gives the metastability settling time the
  // multi-cycle-path scheme relies on.
  localparam int MIN_SYNC_STAGES = 2;

endpackage : bus_sync_mcp_pkg
`default_nettype wire

// File: rtl/bus_sync_mcp_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Single-bit flop chain for bringing a quasi-static control
//                signal into the CLK domain. Reset clears every stage.
//  Ports       : CLK  in   destination clock
//                RST  in   asynchronous active-low reset
//                d_i  in   unsynchronized input
//                q_o  out  synchronized output (last stage)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_chain
  import bus_sync_mcp_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);

  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_chain: NUM_STAGES must be >= 2");
  end else begin : g_chain
    logic [NUM_STAGES-1:0] chain_q;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        chain_q <= '0;
      end else begin
        // Bit 0 is the first (possibly metastable) stage.
        chain_q <= {chain_q[NUM_STAGES-2:0], d_i};
      end
    end

    assign q_o = chain_q[NUM_STAGES-1];
  end

endmodule : sync_chain
`default_nettype wire

// File: rtl/bus_sync_mcp.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sync_mcp
//  Description : Multi-cycle-path bus synchronizer, destination domain.
//                Only the qualifier BUS_EN is synchronized; on a qualifier
//                event the quasi-static ASYNC_BUS is captured once and a
//                1-cycle strobe is emitted. A saturating transfer counter is
//                kept for status readback.
//  Ports       : CLK        in   destination clock
//                RST        in   asynchronous active-low reset
//                ASYNC_BUS  in   source data, unsynchronized
//                BUS_EN     in   source qualifier, unsynchronized
//                CNT_CLR    in   synchronous clear of XFER_CNT
//                SYNC_BUS   out  captured data, held until next event
//                EN_PULSE   out  1-cycle strobe, SYNC_BUS updated this cycle
//                SYNC_VALID out  sticky: at least one capture since reset
//                XFER_CNT   out  saturating event count
//  Revision    : 1.0  initial release
// ============================================================================
module bus_sync_mcp
  import bus_sync_mcp_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 66,
  parameter int EN_MODE    = EN_MODE_LEVEL,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC_BUS,
  input  logic                 BUS_EN,
  input  logic                 CNT_CLR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 EN_PULSE,
  output logic                 SYNC_VALID,
  output logic [CNT_WIDTH-1:0] XFER_CNT
);

  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("bus_sync_mcp: NUM_STAGES must be >= 2");
  end

  logic                 en_s;
  logic                 evt;

  logic                 en_prev_q,    en_prev_d;
  logic [BUS_WIDTH-1:0] sync_bus_q,   sync_bus_d;
  logic                 en_pulse_q,   en_pulse_d;
  logic                 sync_valid_q, sync_valid_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q,   xfer_cnt_d;

  sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .CLK (CLK),
    .RST (RST),
    .d_i (BUS_EN),
    .q_o (en_s)
  );

  // en_prev resets to 0, so a qualifier already high at reset release is
  // seen as an edge once it reaches the end of the chain.
  if (EN_MODE == EN_MODE_TOGGLE) begin : g_evt_toggle
    assign evt = en_s ^ en_prev_q;
  end else begin : g_evt_level
    assign evt = en_s & ~en_prev_q;
  end

  always_comb begin
    en_prev_d    = en_s;
    sync_bus_d   = sync_bus_q;
    en_pulse_d   = 1'b0;
    sync_valid_d = sync_valid_q;
    xfer_cnt_d   = xfer_cnt_q;

    // ASYNC_BUS is only sampled here: by the time evt fires the source
    // contract guarantees the bus has been stable for the chain latency.
    if (evt) begin
      sync_bus_d   = ASYNC_BUS;
      en_pulse_d   = 1'b1;
      sync_valid_d = 1'b1;
    end

    // A clear coinciding with an event leaves that event counted.
    if (CNT_CLR) begin
      xfer_cnt_d = evt ? CNT_WIDTH'(1) : '0;
    end else if (evt && !(&xfer_cnt_q)) begin
      xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_prev_q    <= 1'b0;
      sync_bus_q   <= '0;
      en_pulse_q   <= 1'b0;
      sync_valid_q <= 1'b0;
      xfer_cnt_q   <= '0;
    end else begin
      en_prev_q    <= en_prev_d;
      sync_bus_q   <= sync_bus_d;
      en_pulse_q   <= en_pulse_d;
      sync_valid_q <= sync_valid_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign SYNC_BUS   = sync_bus_q;
  assign EN_PULSE   = en_pulse_q;
  assign SYNC_VALID = sync_valid_q;
  assign XFER_CNT   = xfer_cnt_q;

endmodule : bus_sync_mcp
`default_nettype wire
